// File: rtl/decode.sv
// RV64I instruction decode stage: registers decoded fields for execute, detects load-use
// hazards against the held instruction and inserts a bubble while fetch holds.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic [63:0] pc_in,
    input  logic [63:0] instr_in,
    input  logic        branch_predicted_taken_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [63:0] pc_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [63:0] imm_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_src1_pc_out,
    output logic        alu_src2_imm_out,
    output logic        word_op_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [1:0]  mem_width_out,
    output logic        mem_unsigned_out,
    output logic        reg_write_out,
    output logic        branch_out,
    output logic        jal_out,
    output logic        jalr_out,
    output logic [2:0]  branch_funct3_out,
    output logic        branch_predicted_taken_out,
    output logic        illegal_out
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpOp32   = 7'b0111011;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [3:0]  alu_op;
        logic        src1_pc;
        logic        src2_imm;
        logic        word_op;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_width;
        logic        mem_unsigned;
        logic        reg_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic [2:0]  branch_funct3;
        logic        pred_taken;
        logic        illegal;
    } dec_t;

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    logic [31:0] ins;
    logic        unused_hi;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        f7_zero;
    logic        f7_alt;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;
    logic        legal;
    logic        uses_rs1;
    logic        uses_rs2;
    dec_t        dec_d;
    dec_t        dec_q;
    dec_t        bubble;

    assign ins       = instr_in[31:0];
    assign unused_hi = ^instr_in[63:32];
    assign opcode    = ins[6:0];
    assign rd        = ins[11:7];
    assign funct3    = ins[14:12];
    assign rs1       = ins[19:15];
    assign rs2       = ins[24:20];
    assign funct7    = ins[31:25];
    assign f7_zero   = (funct7 == 7'b0000000);
    assign f7_alt    = (funct7 == 7'b0100000);

    assign imm_i = {{52{ins[31]}}, ins[31:20]};
    assign imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
    assign imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    assign uses_rs1 = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
    assign uses_rs2 = (opcode == OpOp) || (opcode == OpOp32) || (opcode == OpStore) ||
                      (opcode == OpBranch);

    always_comb begin
        dec_d            = '0;
        legal            = 1'b1;
        dec_d.valid      = 1'b1;
        dec_d.pc         = pc_in;
        dec_d.rs1        = rs1;
        dec_d.rs2        = rs2;
        dec_d.rd         = rd;
        dec_d.pred_taken = branch_predicted_taken_in;
        case (opcode)
            OpLui: begin
                dec_d.imm       = imm_u;
                dec_d.alu_op    = AluPassB;
                dec_d.src2_imm  = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OpAuipc: begin
                dec_d.imm       = imm_u;
                dec_d.src1_pc   = 1'b1;
                dec_d.src2_imm  = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OpJal: begin
                dec_d.imm       = imm_j;
                dec_d.src1_pc   = 1'b1;
                dec_d.src2_imm  = 1'b1;
                dec_d.jal       = 1'b1;
                dec_d.reg_write = 1'b1;
            end
            OpJalr: begin
                dec_d.imm       = imm_i;
                dec_d.src2_imm  = 1'b1;
                dec_d.jalr      = 1'b1;
                dec_d.reg_write = 1'b1;
                legal           = (funct3 == 3'b000);
            end
            OpBranch: begin
                dec_d.imm           = imm_b;
                dec_d.branch        = 1'b1;
                dec_d.branch_funct3 = funct3;
                legal               = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OpLoad: begin
                dec_d.imm          = imm_i;
                dec_d.src2_imm     = 1'b1;
                dec_d.mem_read     = 1'b1;
                dec_d.mem_width    = funct3[1:0];
                dec_d.mem_unsigned = funct3[2];
                dec_d.reg_write    = 1'b1;
                legal              = (funct3 != 3'b111);
            end
            OpStore: begin
                dec_d.imm       = imm_s;
                dec_d.src2_imm  = 1'b1;
                dec_d.mem_write = 1'b1;
                dec_d.mem_width = funct3[1:0];
                legal           = !funct3[2];
            end
            OpImm: begin
                dec_d.imm       = imm_i;
                dec_d.src2_imm  = 1'b1;
                dec_d.alu_op    = alu_of(funct3, ins[30] && (funct3 == 3'b101));
                dec_d.reg_write = 1'b1;
                // RV64 shamt is 6 bits, so only ins[31:26] carry the shift-type encoding.
                if (funct3 == 3'b001) begin
                    legal = (ins[31:26] == 6'b000000);
                end else if (funct3 == 3'b101) begin
                    legal = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000);
                end
            end
            OpImm32: begin
                dec_d.imm       = imm_i;
                dec_d.src2_imm  = 1'b1;
                dec_d.word_op   = 1'b1;
                dec_d.alu_op    = alu_of(funct3, ins[30] && (funct3 == 3'b101));
                dec_d.reg_write = 1'b1;
                legal           = (funct3 == 3'b000) ||
                                  ((funct3 == 3'b001) && f7_zero) ||
                                  ((funct3 == 3'b101) && (f7_zero || f7_alt));
            end
            OpOp: begin
                dec_d.alu_op    = alu_of(funct3, ins[30]);
                dec_d.reg_write = 1'b1;
                legal           = f7_zero ||
                                  (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OpOp32: begin
                dec_d.word_op   = 1'b1;
                dec_d.alu_op    = alu_of(funct3, ins[30]);
                dec_d.reg_write = 1'b1;
                legal           = (((funct3 == 3'b000) || (funct3 == 3'b101)) &&
                                   (f7_zero || f7_alt)) ||
                                  ((funct3 == 3'b001) && f7_zero);
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_d         = '0;
            dec_d.valid   = 1'b1;
            dec_d.pc      = pc_in;
            dec_d.rs1     = rs1;
            dec_d.rs2     = rs2;
            dec_d.rd      = rd;
            dec_d.illegal = 1'b1;
        end

        if (dec_d.rd == 5'd0) begin
            dec_d.reg_write = 1'b0;
        end
    end

    always_comb begin
        bubble    = '0;
        bubble.pc = pc_in;
    end

    assign stall_out = !reset && dec_q.valid && dec_q.mem_read && (dec_q.rd != 5'd0) &&
                       ((uses_rs1 && (rs1 == dec_q.rd)) || (uses_rs2 && (rs2 == dec_q.rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q <= '0;
        end else if (!stall_in) begin
            if (flush_in || stall_out) begin
                dec_q <= bubble;
            end else begin
                dec_q <= dec_d;
            end
        end
    end

    assign valid_out                  = dec_q.valid;
    assign pc_out                     = dec_q.pc;
    assign rs1_out                    = dec_q.rs1;
    assign rs2_out                    = dec_q.rs2;
    assign rd_out                     = dec_q.rd;
    assign imm_out                    = dec_q.imm;
    assign alu_op_out                 = dec_q.alu_op;
    assign alu_src1_pc_out            = dec_q.src1_pc;
    assign alu_src2_imm_out           = dec_q.src2_imm;
    assign word_op_out                = dec_q.word_op;
    assign mem_read_out               = dec_q.mem_read;
    assign mem_write_out              = dec_q.mem_write;
    assign mem_width_out              = dec_q.mem_width;
    assign mem_unsigned_out           = dec_q.mem_unsigned;
    assign reg_write_out              = dec_q.reg_write;
    assign branch_out                 = dec_q.branch;
    assign jal_out                    = dec_q.jal;
    assign jalr_out                   = dec_q.jalr;
    assign branch_funct3_out          = dec_q.branch_funct3;
    assign branch_predicted_taken_out = dec_q.pred_taken;
    assign illegal_out                = dec_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage with hand-computed expectations.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        flush_in;
    logic [63:0] pc_in;
    logic [63:0] instr_in;
    logic        branch_predicted_taken_in;
    logic        stall_out;
    logic        valid_out;
    logic [63:0] pc_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [63:0] imm_out;
    logic [3:0]  alu_op_out;
    logic        alu_src1_pc_out;
    logic        alu_src2_imm_out;
    logic        word_op_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [1:0]  mem_width_out;
    logic        mem_unsigned_out;
    logic        reg_write_out;
    logic        branch_out;
    logic        jal_out;
    logic        jalr_out;
    logic [2:0]  branch_funct3_out;
    logic        branch_predicted_taken_out;
    logic        illegal_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode dut (
        .clk                        (clk),
        .reset                      (reset),
        .stall_in                   (stall_in),
        .flush_in                   (flush_in),
        .pc_in                      (pc_in),
        .instr_in                   (instr_in),
        .branch_predicted_taken_in  (branch_predicted_taken_in),
        .stall_out                  (stall_out),
        .valid_out                  (valid_out),
        .pc_out                     (pc_out),
        .rs1_out                    (rs1_out),
        .rs2_out                    (rs2_out),
        .rd_out                     (rd_out),
        .imm_out                    (imm_out),
        .alu_op_out                 (alu_op_out),
        .alu_src1_pc_out            (alu_src1_pc_out),
        .alu_src2_imm_out           (alu_src2_imm_out),
        .word_op_out                (word_op_out),
        .mem_read_out               (mem_read_out),
        .mem_write_out              (mem_write_out),
        .mem_width_out              (mem_width_out),
        .mem_unsigned_out           (mem_unsigned_out),
        .reg_write_out              (reg_write_out),
        .branch_out                 (branch_out),
        .jal_out                    (jal_out),
        .jalr_out                   (jalr_out),
        .branch_funct3_out          (branch_funct3_out),
        .branch_predicted_taken_out (branch_predicted_taken_out),
        .illegal_out                (illegal_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] ins, input logic pred);
        pc_in                     = pc;
        instr_in                  = {32'hDEADBEEF, ins};
        branch_predicted_taken_in = pred;
    endtask

    initial begin
        // Reset with random inputs for two edges.
        reset    = 1'b1;
        stall_in = 1'($urandom);
        flush_in = 1'($urandom);
        drive({$urandom, $urandom}, $urandom, 1'($urandom));
        step();
        stall_in = 1'($urandom);
        flush_in = 1'($urandom);
        drive({$urandom, $urandom}, $urandom, 1'($urandom));
        step();
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_pc", pc_out, 64'd0);
        check("rst_imm", imm_out, 64'd0);
        check("rst_alu", 64'(alu_op_out), 64'd0);
        check("rst_strobes", 64'({reg_write_out, mem_read_out, mem_write_out, branch_out,
                                  jal_out, jalr_out, illegal_out,
                                  branch_predicted_taken_out}), 64'd0);
        check("rst_stall", 64'(stall_out), 64'd0);
        reset    = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;

        // addi x5,x0,-1
        drive(64'h100, 32'hFFF00293, 1'b0);
        step();
        check("addi_valid", 64'(valid_out), 64'd1);
        check("addi_pc", pc_out, 64'h100);
        check("addi_rd", 64'(rd_out), 64'd5);
        check("addi_rs1", 64'(rs1_out), 64'd0);
        check("addi_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_alu", 64'(alu_op_out), 64'd0);
        check("addi_src2imm", 64'(alu_src2_imm_out), 64'd1);
        check("addi_regwr", 64'(reg_write_out), 64'd1);

        // ld x6,8(x5) then dependent add x7,x6,x1
        drive(64'h104, 32'h0082B303, 1'b0);
        #1;
        check("ld_nostall", 64'(stall_out), 64'd0);
        step();
        check("ld_memrd", 64'(mem_read_out), 64'd1);
        check("ld_rd", 64'(rd_out), 64'd6);
        check("ld_width", 64'(mem_width_out), 64'd3);
        check("ld_imm", imm_out, 64'd8);
        drive(64'h108, 32'h001303B3, 1'b0);
        #1;
        check("lu_stall", 64'(stall_out), 64'd1);
        step();
        check("lu_bub_valid", 64'(valid_out), 64'd0);
        check("lu_bub_rd", 64'(rd_out), 64'd0);
        check("lu_bub_pc", pc_out, 64'h108);
        check("lu_stall_clr", 64'(stall_out), 64'd0);
        step();
        check("add_valid", 64'(valid_out), 64'd1);
        check("add_rs1", 64'(rs1_out), 64'd6);
        check("add_rs2", 64'(rs2_out), 64'd1);
        check("add_rd", 64'(rd_out), 64'd7);
        check("add_pc", pc_out, 64'h108);

        // ld x0 then the same consumer: no hazard
        drive(64'h10C, 32'h0082B003, 1'b0);
        step();
        check("ldx0_regwr", 64'(reg_write_out), 64'd0);
        drive(64'h110, 32'h001303B3, 1'b0);
        #1;
        check("ldx0_nostall", 64'(stall_out), 64'd0);
        step();
        check("ldx0_add_valid", 64'(valid_out), 64'd1);
        check("ldx0_add_pc", pc_out, 64'h110);

        // beq x1,x2,-8 predicted taken
        drive(64'h114, 32'hFE208CE3, 1'b1);
        step();
        check("beq_branch", 64'(branch_out), 64'd1);
        check("beq_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFF8);
        check("beq_f3", 64'(branch_funct3_out), 64'd0);
        check("beq_pred", 64'(branch_predicted_taken_out), 64'd1);
        check("beq_regwr", 64'(reg_write_out), 64'd0);
        check("beq_rs2", 64'(rs2_out), 64'd2);

        // Downstream stall with flush asserted: outputs frozen
        stall_in = 1'b1;
        flush_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(64'h200 + 64'(i * 4), 32'h123451B7, 1'b0);
            step();
            check("stall_pc", pc_out, 64'h114);
            check("stall_branch", 64'(branch_out), 64'd1);
            check("stall_pred", 64'(branch_predicted_taken_out), 64'd1);
        end
        stall_in = 1'b0;
        drive(64'h300, 32'hFFF00293, 1'b1);
        step();
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_pc", pc_out, 64'h300);
        check("flush_strobes", 64'({reg_write_out, branch_out, branch_predicted_taken_out,
                                    rd_out}), 64'd0);
        flush_in = 1'b0;

        // lui x3,0x12345
        drive(64'h304, 32'h123451B7, 1'b0);
        step();
        check("lui_imm", imm_out, 64'h12345000);
        check("lui_alu", 64'(alu_op_out), 64'd10);
        check("lui_rd", 64'(rd_out), 64'd3);

        // Unknown opcode with nonzero rd and prediction set
        drive(64'h308, 32'h0000037F, 1'b1);
        step();
        check("ill_valid", 64'(valid_out), 64'd1);
        check("ill_flag", 64'(illegal_out), 64'd1);
        check("ill_strobes", 64'({reg_write_out, mem_read_out, mem_write_out,
                                  branch_predicted_taken_out}), 64'd0);

        // Hazard visible while stalled, then reset wins over the stall
        drive(64'h30C, 32'h0082B303, 1'b0);
        step();
        stall_in = 1'b1;
        drive(64'h310, 32'h001303B3, 1'b0);
        #1;
        check("hz_under_stall", 64'(stall_out), 64'd1);
        reset = 1'b1;
        step();
        check("rst_mid_valid", 64'(valid_out), 64'd0);
        check("rst_mid_pc", pc_out, 64'd0);
        check("rst_mid_stall", 64'(stall_out), 64'd0);
        reset    = 1'b0;
        stall_in = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
